// File: rtl/sys_spm_pkg.sv
// sys_spm_pkg: shared SPM AXI-LT types, OSR limits and the OSR gate state encoding.
package sys_spm_pkg;
  localparam int unsigned SYS_SPM_MAX_WR_OSR = 16;
  localparam int unsigned SYS_SPM_MAX_RD_OSR = 16;
  typedef logic [$clog2(SYS_SPM_MAX_WR_OSR+1)-1:0] sys_spm_wr_osr_t;
  typedef logic [$clog2(SYS_SPM_MAX_RD_OSR+1)-1:0] sys_spm_rd_osr_t;
  typedef enum logic [1:0] {RUN, DRAIN, QUIESCED} sys_spm_osr_state_e;
  typedef logic [3:0]  sys_spm_targ_lt_axi_id_t;
  typedef logic [31:0] sys_spm_axi_addr_t;
  typedef logic [63:0] sys_spm_axi_data_t;
  typedef logic [7:0]  sys_spm_axi_strb_t;
  typedef logic [7:0]  sys_spm_axi_len_t;
  typedef logic [2:0]  sys_spm_axi_size_t;
  typedef logic [1:0]  sys_spm_axi_burst_t;
  typedef logic [3:0]  sys_spm_axi_cache_t;
  typedef logic [2:0]  sys_spm_axi_prot_t;
  typedef logic [1:0]  sys_spm_axi_resp_t;
endpackage

// File: rtl/sys_spm_osr_chan.sv
// sys_spm_osr_chan: outstanding-request counter, valid commit hold, gate and underflow flag for one direction.
module sys_spm_osr_chan #(
  parameter int unsigned MAX = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_run,
  input  logic                     i_svalid,
  input  logic                     i_mready,
  input  logic                     i_rsp,
  output logic                     o_mvalid,
  output logic                     o_sready,
  output logic                     o_commit,
  output logic                     o_underflow,
  output logic [$clog2(MAX+1)-1:0] o_cnt
);
  localparam int unsigned W = $clog2(MAX+1);
  localparam logic [W-1:0] MAXV = W'(MAX);
  logic [W-1:0] cnt_q, cnt_d;
  logic commit_q, commit_d, uf_q, uf_d, open, hs;
  always_comb begin
    open = (i_run && cnt_q < MAXV) || commit_q;
    o_mvalid = i_svalid & open;
    o_sready = i_mready & open;
    hs = o_mvalid & i_mready;
    // a valid shown to the target must stay up until taken, whatever the gate state does
    commit_d = o_mvalid & ~i_mready;
    uf_d = uf_q | (i_rsp && cnt_q == '0);
    cnt_d = (hs && !i_rsp) ? cnt_q + W'(1) : (i_rsp && !hs && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      commit_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      commit_q <= commit_d;
      uf_q <= uf_d;
    end
  end
  assign o_cnt = cnt_q;
  assign o_commit = commit_q;
  assign o_underflow = uf_q;
endmodule

// File: rtl/sys_spm_axi_osr_gate.sv
// sys_spm_axi_osr_gate: AXI-LT OSR limiter and quiesce handshake in front of the SPM.
// Optional SYS_SPM_OSR_PERF_CNT_EN adds peak-count and stall-cycle counters.
module sys_spm_axi_osr_gate
  import sys_spm_pkg::*;
#(
  parameter int unsigned MAX_WR_OSR = SYS_SPM_MAX_WR_OSR,
  parameter int unsigned MAX_RD_OSR = SYS_SPM_MAX_RD_OSR,
  parameter type axi_id_t = sys_spm_targ_lt_axi_id_t
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  sys_spm_axi_addr_t               i_axi_s_awaddr,
  input  axi_id_t                         i_axi_s_awid,
  input  sys_spm_axi_len_t                i_axi_s_awlen,
  input  sys_spm_axi_size_t               i_axi_s_awsize,
  input  sys_spm_axi_burst_t              i_axi_s_awburst,
  input  logic                            i_axi_s_awlock,
  input  sys_spm_axi_cache_t              i_axi_s_awcache,
  input  sys_spm_axi_prot_t               i_axi_s_awprot,
  input  logic                            i_axi_s_awvalid,
  output logic                            o_axi_s_awready,
  output sys_spm_axi_addr_t               o_axi_m_awaddr,
  output axi_id_t                         o_axi_m_awid,
  output sys_spm_axi_len_t                o_axi_m_awlen,
  output sys_spm_axi_size_t               o_axi_m_awsize,
  output sys_spm_axi_burst_t              o_axi_m_awburst,
  output logic                            o_axi_m_awlock,
  output sys_spm_axi_cache_t              o_axi_m_awcache,
  output sys_spm_axi_prot_t               o_axi_m_awprot,
  output logic                            o_axi_m_awvalid,
  input  logic                            i_axi_m_awready,
  input  sys_spm_axi_addr_t               i_axi_s_araddr,
  input  axi_id_t                         i_axi_s_arid,
  input  sys_spm_axi_len_t                i_axi_s_arlen,
  input  sys_spm_axi_size_t               i_axi_s_arsize,
  input  sys_spm_axi_burst_t              i_axi_s_arburst,
  input  logic                            i_axi_s_arlock,
  input  sys_spm_axi_cache_t              i_axi_s_arcache,
  input  sys_spm_axi_prot_t               i_axi_s_arprot,
  input  logic                            i_axi_s_arvalid,
  output logic                            o_axi_s_arready,
  output sys_spm_axi_addr_t               o_axi_m_araddr,
  output axi_id_t                         o_axi_m_arid,
  output sys_spm_axi_len_t                o_axi_m_arlen,
  output sys_spm_axi_size_t               o_axi_m_arsize,
  output sys_spm_axi_burst_t              o_axi_m_arburst,
  output logic                            o_axi_m_arlock,
  output sys_spm_axi_cache_t              o_axi_m_arcache,
  output sys_spm_axi_prot_t               o_axi_m_arprot,
  output logic                            o_axi_m_arvalid,
  input  logic                            i_axi_m_arready,
  input  sys_spm_axi_data_t               i_axi_s_wdata,
  input  sys_spm_axi_strb_t               i_axi_s_wstrb,
  input  logic                            i_axi_s_wlast,
  input  logic                            i_axi_s_wvalid,
  output logic                            o_axi_s_wready,
  output sys_spm_axi_data_t               o_axi_m_wdata,
  output sys_spm_axi_strb_t               o_axi_m_wstrb,
  output logic                            o_axi_m_wlast,
  output logic                            o_axi_m_wvalid,
  input  logic                            i_axi_m_wready,
  input  logic                            i_axi_m_bvalid,
  input  axi_id_t                         i_axi_m_bid,
  input  sys_spm_axi_resp_t               i_axi_m_bresp,
  output logic                            o_axi_m_bready,
  output logic                            o_axi_s_bvalid,
  output axi_id_t                         o_axi_s_bid,
  output sys_spm_axi_resp_t               o_axi_s_bresp,
  input  logic                            i_axi_s_bready,
  input  logic                            i_axi_m_rvalid,
  input  logic                            i_axi_m_rlast,
  input  axi_id_t                         i_axi_m_rid,
  input  sys_spm_axi_data_t               i_axi_m_rdata,
  input  sys_spm_axi_resp_t               i_axi_m_rresp,
  output logic                            o_axi_m_rready,
  output logic                            o_axi_s_rvalid,
  output logic                            o_axi_s_rlast,
  output axi_id_t                         o_axi_s_rid,
  output sys_spm_axi_data_t               o_axi_s_rdata,
  output sys_spm_axi_resp_t               o_axi_s_rresp,
  input  logic                            i_axi_s_rready,
  input  logic                            i_quiesce_req,
  output logic                            o_quiesce_ack,
  output logic [$clog2(MAX_WR_OSR+1)-1:0] o_wr_osr,
  output logic [$clog2(MAX_RD_OSR+1)-1:0] o_rd_osr,
`ifdef SYS_SPM_OSR_PERF_CNT_EN
  input  logic                            i_perf_clr,
  output logic [$clog2(MAX_WR_OSR+1)-1:0] o_wr_osr_peak,
  output logic [$clog2(MAX_RD_OSR+1)-1:0] o_rd_osr_peak,
  output logic [31:0]                     o_stall_cycles,
`endif
  output logic                            o_err_underflow
);
  sys_spm_osr_state_e state_q, state_d;
  logic ack_q, run, drained, aw_commit, ar_commit, wr_uf, rd_uf;
  assign {o_axi_m_awaddr, o_axi_m_awid, o_axi_m_awlen, o_axi_m_awsize, o_axi_m_awburst, o_axi_m_awlock, o_axi_m_awcache, o_axi_m_awprot} =
         {i_axi_s_awaddr, i_axi_s_awid, i_axi_s_awlen, i_axi_s_awsize, i_axi_s_awburst, i_axi_s_awlock, i_axi_s_awcache, i_axi_s_awprot};
  assign {o_axi_m_araddr, o_axi_m_arid, o_axi_m_arlen, o_axi_m_arsize, o_axi_m_arburst, o_axi_m_arlock, o_axi_m_arcache, o_axi_m_arprot} =
         {i_axi_s_araddr, i_axi_s_arid, i_axi_s_arlen, i_axi_s_arsize, i_axi_s_arburst, i_axi_s_arlock, i_axi_s_arcache, i_axi_s_arprot};
  assign {o_axi_m_wdata, o_axi_m_wstrb, o_axi_m_wlast, o_axi_m_wvalid, o_axi_s_wready} =
         {i_axi_s_wdata, i_axi_s_wstrb, i_axi_s_wlast, i_axi_s_wvalid, i_axi_m_wready};
  assign {o_axi_s_bvalid, o_axi_s_bid, o_axi_s_bresp, o_axi_m_bready} = {i_axi_m_bvalid, i_axi_m_bid, i_axi_m_bresp, i_axi_s_bready};
  assign {o_axi_s_rvalid, o_axi_s_rlast, o_axi_s_rid, o_axi_s_rdata, o_axi_s_rresp, o_axi_m_rready} =
         {i_axi_m_rvalid, i_axi_m_rlast, i_axi_m_rid, i_axi_m_rdata, i_axi_m_rresp, i_axi_s_rready};
  sys_spm_osr_chan #(.MAX(MAX_WR_OSR)) u_wr (
    .i_clk(i_clk), .i_rst(i_rst), .i_run(run), .i_svalid(i_axi_s_awvalid), .i_mready(i_axi_m_awready),
    .i_rsp(i_axi_m_bvalid & i_axi_s_bready), .o_mvalid(o_axi_m_awvalid), .o_sready(o_axi_s_awready),
    .o_commit(aw_commit), .o_underflow(wr_uf), .o_cnt(o_wr_osr)
  );
  sys_spm_osr_chan #(.MAX(MAX_RD_OSR)) u_rd (
    .i_clk(i_clk), .i_rst(i_rst), .i_run(run), .i_svalid(i_axi_s_arvalid), .i_mready(i_axi_m_arready),
    .i_rsp(i_axi_m_rvalid & i_axi_s_rready & i_axi_m_rlast), .o_mvalid(o_axi_m_arvalid), .o_sready(o_axi_s_arready),
    .o_commit(ar_commit), .o_underflow(rd_uf), .o_cnt(o_rd_osr)
  );
  always_comb begin
    run = state_q == RUN;
    drained = o_wr_osr == '0 && o_rd_osr == '0 && !aw_commit && !ar_commit;
    state_d = !i_quiesce_req ? RUN : run ? DRAIN : (state_q == DRAIN && drained) ? QUIESCED : state_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RUN;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q <= state_d == QUIESCED;
    end
  end
  assign o_quiesce_ack = ack_q;
  assign o_err_underflow = wr_uf | rd_uf;
`ifdef SYS_SPM_OSR_PERF_CNT_EN
  logic [$clog2(MAX_WR_OSR+1)-1:0] wr_peak_q;
  logic [$clog2(MAX_RD_OSR+1)-1:0] rd_peak_q;
  logic [31:0] stall_q;
  logic blocked;
  // upstream valid that the gate is holding back
  assign blocked = (i_axi_s_awvalid & ~o_axi_m_awvalid) | (i_axi_s_arvalid & ~o_axi_m_arvalid);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_peak_q <= '0;
      rd_peak_q <= '0;
      stall_q <= '0;
    end else if (i_perf_clr) begin
      wr_peak_q <= '0;
      rd_peak_q <= '0;
      stall_q <= '0;
    end else begin
      wr_peak_q <= (o_wr_osr > wr_peak_q) ? o_wr_osr : wr_peak_q;
      rd_peak_q <= (o_rd_osr > rd_peak_q) ? o_rd_osr : rd_peak_q;
      stall_q <= (blocked && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    end
  end
  assign o_wr_osr_peak = wr_peak_q;
  assign o_rd_osr_peak = rd_peak_q;
  assign o_stall_cycles = stall_q;
`endif
endmodule

// File: doc/sys_spm_axi_osr_gate.md
Name: sys_spm_axi_osr_gate

Overview:
- AXI-LT front stage directly upstream of the sys_spm target; every LT transaction to the SPM passes through it.
- Limits outstanding write and read transactions to the SPM's OSR capacity.
- Gives the power controller a quiesce handshake: drain all traffic, then hold the SPM idle before RAM ret/pde is asserted.
- Address payloads and the W, B and R channels are combinational pass-through; only AW/AR valid/ready are gated, and B/R handshakes are snooped.

Parameters:
- MAX_WR_OSR, 16, maximum outstanding writes (AW accepted, B not yet taken).
- MAX_RD_OSR, 16, maximum outstanding reads (AR accepted, last R beat not yet taken).
- axi_id_t, sys_spm_targ_lt_axi_id_t, ID type carried on all channels.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_axi_s_aw{addr,id,len,size,burst,lock,cache,prot}  in  chip/axi_pkg types  AW payload, forwarded unchanged to o_axi_m_aw*.
- i_axi_s_awvalid  in  1  upstream AW valid.
- o_axi_s_awready  out  1  upstream AW ready.
- o_axi_m_aw{payload}  out  as input  AW payload to SPM.
- o_axi_m_awvalid  out  1  gated AW valid to SPM.
- i_axi_m_awready  in  1  SPM AW ready.
- i_axi_s_ar*, o_axi_s_arready, o_axi_m_ar*, i_axi_m_arready  —  AR channel, same structure as AW.
- W channel (wdata, wstrb, wlast, wvalid, wready)  s<->m  —  pure wires, not gated.
- B channel (bvalid, bid, bresp, bready)  s<->m  —  pure wires; handshake snooped.
- R channel (rvalid, rlast, rid, rdata, rresp, rready)  s<->m  —  pure wires; handshake snooped.
- i_quiesce_req  in  1  level request to drain and block new traffic.
- o_quiesce_ack  out  1  registered; high while quiesced.
- o_wr_osr  out  $clog2(MAX_WR_OSR+1)  current outstanding write count.
- o_rd_osr  out  $clog2(MAX_RD_OSR+1)  current outstanding read count.
- o_err_underflow  out  1  sticky; set on a B or R-last response arriving with its counter at 0.

Behaviour:
- Reset values:
  - counters 0; state RUN; o_quiesce_ack 0; o_err_underflow 0; commit flags 0.
  - o_axi_m_awvalid and o_axi_m_arvalid follow the gating equation, so they are 0 while the upstream valid is 0.
- Write gate:
  - open = (state==RUN && wr_osr<MAX_WR_OSR) || aw_commit.
  - o_axi_m_awvalid = i_axi_s_awvalid & open.
  - o_axi_s_awready = i_axi_m_awready & open.
  - Zero-cycle combinational path; no added latency.
- aw_commit (AXI valid-stability rule):
  - Set when o_axi_m_awvalid=1 and i_axi_m_awready=0.
  - Cleared on the AW handshake.
  - Keeps a presented AW valid asserted until accepted, even if quiesce arrives or the counter state changes.
- Write counter:
  - +1 on AW handshake (m side); -1 on B handshake.
  - Both in the same cycle: no change.
  - B handshake at count 0: count stays 0, o_err_underflow set.
  - Never exceeds MAX_WR_OSR; at the limit, awready stays low until a B handshake. The gate reopens the cycle after the decrement.
- Read path: identical structure, using AR, ar_commit and MAX_RD_OSR. Decrement only on an R handshake with rlast=1.
- State machine:
  - RUN -> DRAIN when i_quiesce_req=1.
  - DRAIN -> RUN when i_quiesce_req=0.
  - DRAIN -> QUIESCED when wr_osr==0, rd_osr==0, aw_commit==0 and ar_commit==0, with request still high.
  - QUIESCED -> RUN when i_quiesce_req=0.
  - o_quiesce_ack = (state==QUIESCED), registered. Asserts the cycle after the drain condition holds; drops the cycle after the request falls.
  - DRAIN and QUIESCED block new AW/AR; committed valids still complete.
- Pending W beats and responses always flow; the gate never blocks W, B or R.
- o_err_underflow clears only on reset.
- Reset mid-transaction: all state cleared; upstream and SPM are reset together by the system.

Optional Feature:
- Macro: SYS_SPM_OSR_PERF_CNT_EN.
- Defined:
  - adds o_wr_osr_peak and o_rd_osr_peak (counter width): highest count seen since reset.
  - adds o_stall_cycles (32-bit, saturating): cycles with upstream AW or AR valid=1 blocked by the gate (valid high, gate closed).
  - adds i_perf_clr (1-bit): synchronous clear of all three.
- Undefined: the ports and logic are absent.

Decomposition:
- sys_spm_pkg gains:
  - sys_spm_osr_state_e (RUN, DRAIN, QUIESCED);
  - SYS_SPM_MAX_WR_OSR = 16 and SYS_SPM_MAX_RD_OSR = 16, shared with the sys_spm instance;
  - osr count typedefs.
- One sub-module, sys_spm_osr_chan: counter, commit flag, gate and underflow for one direction. Instantiated twice (write, read); the FSM stays in the top.

Test Plan:
- Issue 16 AWs with bready=0:
  - all 16 accepted, o_wr_osr=16;
  - the 17th AW sees awready=0;
  - one B handshake gives o_wr_osr=15 and the 17th AW is accepted the following cycle.
- Reads with arlen=3 for 4 beats:
  - o_rd_osr decrements only on the beat with rlast=1;
  - 16 reads in flight block the next AR.
- Same-cycle AW handshake and B handshake at o_wr_osr=5 -> o_wr_osr stays 5.
- Quiesce drain:
  - start with 3 writes and 2 reads outstanding, then raise i_quiesce_req;
  - new AR is blocked;
  - o_quiesce_ack rises one cycle after the last response;
  - dropping the request gives ack=0 next cycle and traffic resumes.
- Commit hold:
  - awvalid=1 while the SPM holds awready=0, then raise i_quiesce_req;
  - o_axi_m_awvalid stays 1 until the handshake;
  - ack waits for that write's B.
- Spurious B with o_wr_osr=0 -> o_err_underflow=1 and stays set; o_wr_osr stays 0.
